// File: rtl/au_pkg.sv
// Shared types and helpers for the arithmetic-unit bit-scan stage.
package au_pkg;

    typedef enum logic {
        StIdle,
        StScan
    } au_state_e;

    // Index width for a vector of v bits; never narrower than one bit.
    function automatic int unsigned clogb2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (longint'(v) > (longint'(1) << i)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/au_encode_prio.sv
// Combinational priority encoder: selects the lowest (or highest) set bit and
// flags whether more than one bit remains set.
module au_encode_prio
    import au_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    localparam int unsigned IW       = clogb2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IW-1:0]    idx_o,
    output logic             multi_o
);

    always_comb begin
        idx_o = '0;
        if (LSB_FIRST) begin
            // Later assignments win, so scanning downward leaves the lowest set bit.
            for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
                if (vec_i[i]) begin
                    idx_o = IW'(i);
                end
            end
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (vec_i[i]) begin
                    idx_o = IW'(i);
                end
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_o = |(vec_i & (vec_i - WIDTH'(1)));

endmodule

// File: rtl/au_encode_stream.sv
// Streams the index of every set bit of an accepted vector, one per beat,
// with valid/ready on both sides and no bubble between back-to-back vectors.
module au_encode_stream
    import au_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1,
    localparam int unsigned IW       = clogb2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IW-1:0]    out_idx,
    output logic             out_first,
    output logic             out_last,
    output logic             out_zero
);

    au_state_e        state_q, state_d;
    logic [WIDTH-1:0] residual_q, residual_d;
    logic             first_q, first_d;
    logic             zero_q, zero_d;

    logic [IW-1:0]    prio_idx;
    logic             prio_multi;
    logic             out_fire;
    logic             in_fire;

    au_encode_prio #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_prio (
        .vec_i   (residual_q),
        .idx_o   (prio_idx),
        .multi_o (prio_multi)
    );

    // Handshake outputs are masked while rst is high, even before the reset edge.
    always_comb begin
        out_valid = !rst && (state_q == StScan);
        out_idx   = out_valid ? prio_idx : '0;
        out_first = out_valid && first_q;
        out_zero  = out_valid && zero_q;
        out_last  = out_valid && !prio_multi;
        out_fire  = out_valid && out_ready;
        in_ready  = !rst && ((state_q == StIdle) || (out_fire && out_last));
        in_fire   = in_valid && in_ready;
    end

    always_comb begin
        state_d    = state_q;
        residual_d = residual_q;
        first_d    = first_q;
        zero_d     = zero_q;
        if (out_fire) begin
            residual_d = residual_q & ~(WIDTH'(1) << prio_idx);
            first_d    = 1'b0;
            if (out_last) begin
                state_d = StIdle;
            end
        end
        // A new vector overrides the final-beat bookkeeping of the previous one.
        if (in_fire) begin
            residual_d = in_data;
            first_d    = 1'b1;
            zero_d     = (in_data == '0);
            state_d    = StScan;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            residual_q <= '0;
            first_q    <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            residual_q <= residual_d;
            first_q    <= first_d;
            zero_q     <= zero_d;
        end
    end

endmodule

// File: tb/tb_au_encode_stream.sv
// Scoreboard bench: several width/order configurations, each with its own
// driver, reference model and monitor, sharing one clock and one tally.
module tb_au_encode_stream;
    import au_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;

    localparam int NCFG = 5;

    typedef struct {
        int idx;
        bit first;
        bit last;
        bit zero;
    } beat_t;

    function automatic int unsigned cfg_w(input int g);
        case (g)
            0:       return 1;
            1:       return 5;
            2:       return 8;
            3:       return 16;
            default: return 8;
        endcase
    endfunction

    function automatic bit cfg_lsb(input int g);
        return g != 4;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int unsigned W   = cfg_w(g);
        localparam bit          LSB = cfg_lsb(g);
        localparam int unsigned IW  = clogb2(W);

        logic          rst, in_valid, in_ready, out_valid, out_ready;
        logic          out_first, out_last, out_zero;
        logic [W-1:0]  in_data;
        logic [IW-1:0] out_idx;

        logic          rst_nx, in_valid_nx;
        logic [W-1:0]  in_data_nx;
        int            rp;
        bit            accepted;
        beat_t         q[$];

        au_encode_stream #(
            .WIDTH     (W),
            .LSB_FIRST (LSB)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_data   (in_data),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .out_idx   (out_idx),
            .out_first (out_first),
            .out_last  (out_last),
            .out_zero  (out_zero)
        );

        task automatic lchk(input string nm, input int act, input int exp);
            chk($sformatf("W%0d/L%0d %s", W, LSB, nm), act, exp);
        endtask

        // Reference: list of set-bit positions in emission order.
        function automatic void push_vec(input logic [W-1:0] v);
            int ids[$];
            for (int i = 0; i < int'(W); i++) begin
                if (v[i]) ids.push_back(i);
            end
            if (!LSB) ids.reverse();
            if (ids.size() == 0) begin
                q.push_back('{0, 1'b1, 1'b1, 1'b1});
            end else begin
                foreach (ids[k]) q.push_back('{ids[k], k == 0, k == ids.size() - 1, 1'b0});
            end
        endfunction

        task automatic step();
            @(negedge clk);
            rst       = rst_nx;
            in_valid  = in_valid_nx;
            in_data   = in_data_nx;
            out_ready = (int'($urandom_range(0, 99)) < rp);
            #1;
            accepted = 1'b0;
            if (!rst && in_valid && in_ready) begin
                push_vec(in_data);
                accepted = 1'b1;
            end
        endtask

        task automatic send(input logic [W-1:0] v, output int n);
            n           = 0;
            in_valid_nx = 1'b1;
            in_data_nx  = v;
            do begin
                step();
                n++;
            end while (!accepted && n < 500);
            lchk("accept", int'(accepted), 1);
            in_valid_nx = 1'b0;
            in_data_nx  = W'($urandom);
        endtask

        task automatic drain();
            int n;
            n = 0;
            do begin
                step();
                n++;
            end while (!(q.size() == 0 && !out_valid) && n < 500);
            lchk("drain", int'(q.size() == 0 && !out_valid), 1);
        endtask

        always @(negedge clk) begin : mon
            beat_t b;
            #2;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    lchk("unexpected beat idx", int'(out_idx), -1);
                end else begin
                    b = q.pop_front();
                    lchk("idx", int'(out_idx), b.idx);
                    lchk("first", int'(out_first), int'(b.first));
                    lchk("last", int'(out_last), int'(b.last));
                    lchk("zero", int'(out_zero), int'(b.zero));
                end
            end
        end

        initial begin : drv
            int n;
            logic [W-1:0] v;
            rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
            rst_nx = 1'b1; in_valid_nx = 1'b0; in_data_nx = '0; rp = 100;
            step();
            step();
            lchk("rst out_valid", int'(out_valid), 0);
            lchk("rst in_ready", int'(in_ready), 0);
            lchk("rst out_idx", int'(out_idx), 0);
            lchk("rst flags", int'({out_first, out_last, out_zero}), 0);
            rst_nx = 1'b0;
            step();
            lchk("post-rst in_ready", int'(in_ready), 1);
            lchk("post-rst out_valid", int'(out_valid), 0);

            send('0, n);
            drain();
            send(W'(16'h5AA5), n);
            drain();

            // Stall: the first beat must hold while the consumer is not ready.
            rp = 0;
            send(W'(1) | (W'(1) << (W - 1)), n);
            repeat (3) begin
                step();
                lchk("stall valid", int'(out_valid), 1);
                lchk("stall idx", int'(out_idx), LSB ? 0 : int'(W) - 1);
                lchk("stall in_ready", int'(in_ready), 0);
            end
            rp = 100;
            drain();

            send(W'(1), n);
            send(W'(1) << (W - 1), n);
            lchk("b2b accept cycles", n, 1);
            drain();

            // Reset in the middle of an all-ones scan discards the remaining beats.
            send('1, n);
            step();
            step();
            rst_nx = 1'b1;
            step();
            lchk("mid-rst out_valid", int'(out_valid), 0);
            lchk("mid-rst in_ready", int'(in_ready), 0);
            q.delete();
            rst_nx = 1'b0;
            step();
            lchk("after-rst out_valid", int'(out_valid), 0);
            lchk("after-rst in_ready", int'(in_ready), 1);
            send(W'(1) << (W / 2), n);
            drain();

            for (int i = 0; i < int'(W); i++) begin
                send(W'(1) << i, n);
                drain();
            end

            repeat (40) begin
                rp = int'($urandom_range(20, 100));
                v  = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
                send(v, n);
                if ($urandom_range(0, 3) == 0) drain();
                repeat ($urandom_range(0, 2)) step();
            end
            rp = 100;
            drain();
            n_done++;
        end
    end

    initial begin : top
        int n;
        n = 0;
        while (n_done < NCFG && n < 60000) begin
            @(posedge clk);
            n++;
        end
        chk("all configs finished", n_done, NCFG);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
